// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO register pair and sequencer for the shared radix-4 multiplier.
// Multiplies run in the background; only HI/LO-touching ops stall.
module muldiv_hilo_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_z,
  input  logic        mul_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic        uns_q, uns_d;

  logic        op_mult;
  logic        op_multu;
  logic        op_mthi;
  logic        op_mtlo;
  logic        op_mfhi;
  logic        op_mflo;
  logic        op_hilo;
  logic        accept;
  logic [31:0] corr;

  // one-hot decode of the HI/LO opcode space
  always_comb begin
    op_mult  = 1'b0;
    op_multu = 1'b0;
    op_mthi  = 1'b0;
    op_mtlo  = 1'b0;
    op_mfhi  = 1'b0;
    op_mflo  = 1'b0;
    unique case (1'b1)
      (op_code == 3'd0): op_mult  = 1'b1;
      (op_code == 3'd1): op_multu = 1'b1;
      (op_code == 3'd2): op_mthi  = 1'b1;
      (op_code == 3'd3): op_mtlo  = 1'b1;
      (op_code == 3'd4): op_mfhi  = 1'b1;
      (op_code == 3'd5): op_mflo  = 1'b1;
      default: ;
    endcase
  end

  assign op_hilo = op_mult | op_multu | op_mthi |
                   op_mtlo | op_mfhi | op_mflo;

  assign stall  = op_valid & op_hilo & (state_q != S_IDLE);
  assign accept = op_valid & ~stall;

  // the multiplier is signed; fix up HI for unsigned operands
  assign corr = uns_q
              ? ((op_a_q[31] ? op_b_q : 32'd0) +
                 (op_b_q[31] ? op_a_q : 32'd0))
              : 32'd0;

  // next-state, latch and HI/LO update logic
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    uns_d   = uns_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && (op_mult || op_multu)) begin
          op_a_d  = rs_data;
          op_b_d  = rt_data;
          uns_d   = op_multu;
          state_d = S_LAUNCH;
        end else if (accept && op_mthi) begin
          hi_d = rs_data;
        end else if (accept && op_mtlo) begin
          lo_d = rs_data;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (!mul_busy) begin
          lo_d    = mul_z[31:0];
          hi_d    = mul_z[63:32] + corr;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      op_a_q  <= 32'd0;
      op_b_q  <= 32'd0;
      uns_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      uns_q   <= uns_d;
    end
  end

  assign mul_start = (state_q == S_LAUNCH);
  assign done      = (state_q == S_WAIT) & ~mul_busy;
  assign mul_a     = op_a_q;
  assign mul_b     = op_b_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

  // MFHI/MFLO read port, zero unless a read is accepted
  always_comb begin
    rd_data = 32'd0;
    if (accept && op_mfhi) rd_data = hi_q;
    if (accept && op_mflo) rd_data = lo_q;
  end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Randomized bench for muldiv_hilo_ctrl with a behavioural
// 33-cycle multiplier and a plain-arithmetic HI/LO reference.
module tb_muldiv_hilo_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        stall;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;
  logic        mul_start;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_z;
  logic        mul_busy;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int start_cnt = 0;

  muldiv_hilo_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_code   (op_code),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .stall     (stall),
    .rd_data   (rd_data),
    .hi        (hi),
    .lo        (lo),
    .done      (done),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_z     (mul_z),
    .mul_busy  (mul_busy)
  );

  always #5 clk = ~clk;

  // signed multiplier model: busy one edge after start, 32 iterations
  int          m_cnt;
  logic [63:0] m_prod;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_busy <= 1'b0;
      m_cnt    <= 0;
      mul_z    <= 64'd0;
      m_prod   <= 64'd0;
    end else if (mul_start) begin
      mul_busy <= 1'b1;
      m_cnt    <= 32;
      m_prod   <= longint'($signed(mul_a)) * longint'($signed(mul_b));
      mul_z    <= {$urandom, $urandom};
    end else if (mul_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        mul_busy <= 1'b0;
        mul_z    <= m_prod;
      end
    end
  end

  // pulse counters, sampled with pre-edge values
  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (mul_start) start_cnt <= start_cnt + 1;
  end

  function automatic logic [63:0] ref_prod(input logic uns,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa;
    longint sb;
    logic [63:0] ua;
    logic [63:0] ub;
    if (uns) begin
      ua = {32'd0, a};
      ub = {32'd0, b};
      return ua * ub;
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return sa * sb;
  endfunction

  // issue one multiply and wait for its done pulse
  task automatic run_mul(input logic [2:0] code, input logic [31:0] a,
                         input logic [31:0] b, output int cyc);
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = code;
    rs_data  = a;
    rt_data  = b;
    @(negedge clk);
    op_valid = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
  endtask

  task automatic write_hl(input logic [2:0] code, input logic [31:0] d);
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = code;
    rs_data  = d;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset    = 1'b1;
    op_valid = 1'b0;
    op_code  = 3'd0;
    rs_data  = 32'd0;
    rt_data  = 32'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({hi, lo} !== 64'd0) begin
      errors++;
      $display("FAIL reset_hilo: got %h expected 0", {hi, lo});
    end
    checks++;
    if ({done, mul_start, stall} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl: got %b expected 000",
               {done, mul_start, stall});
    end
    checks++;
    if (rd_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_rd: got %h expected 0", rd_data);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult_basic;
    int cyc;
    int d0;
    int s0;
    d0 = done_cnt;
    s0 = start_cnt;
    run_mul(3'd0, 32'd7, 32'hFFFF_FFFD, cyc);
    checks++;
    if (cyc !== 34) begin
      errors++;
      $display("FAIL mult_latency: got %0d expected 34", cyc);
    end
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      errors++;
      $display("FAIL mult_7x-3: got %h expected ffffffffffffffeb",
               {hi, lo});
    end
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL mult_done_cnt: got %0d expected 1", done_cnt - d0);
    end
    checks++;
    if (start_cnt - s0 !== 1) begin
      errors++;
      $display("FAIL mult_start_cnt: got %0d expected 1",
               start_cnt - s0);
    end
  endtask

  task automatic test_multu;
    int cyc;
    run_mul(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("FAIL multu_ff: got %h expected fffffffe00000001",
               {hi, lo});
    end
    run_mul(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    checks++;
    if ({hi, lo} !== 64'h0000_0000_0000_0001) begin
      errors++;
      $display("FAIL mult_ff: got %h expected 0000000000000001",
               {hi, lo});
    end
  endtask

  task automatic test_mfhi_stall;
    int n;
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = 3'd0;
    rs_data  = 32'h0001_0000;
    rt_data  = 32'h0001_0000;
    @(negedge clk);
    op_code = 3'd4;
    n = 0;
    while (stall && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 34) begin
      errors++;
      $display("FAIL mfhi_stall_len: got %0d expected 34", n);
    end
    checks++;
    if (rd_data !== 32'd1) begin
      errors++;
      $display("FAIL mfhi_after_stall: got %h expected 1", rd_data);
    end
    op_valid = 1'b0;
    #1;
    checks++;
    if (rd_data !== 32'd0) begin
      errors++;
      $display("FAIL rd_idle_zero: got %h expected 0", rd_data);
    end
  endtask

  task automatic test_mthi_mtlo;
    write_hl(3'd2, 32'hDEAD_BEEF);
    write_hl(3'd3, 32'h1234_5678);
    op_valid = 1'b1;
    op_code  = 3'd5;
    #1;
    checks++;
    if ({stall, rd_data} !== {1'b0, 32'h1234_5678}) begin
      errors++;
      $display("FAIL mflo_idle: got %b/%h expected 0/12345678",
               stall, rd_data);
    end
    checks++;
    if (hi !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL mthi: got %h expected deadbeef", hi);
    end
    op_code = 3'd4;
    #1;
    checks++;
    if (rd_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL mfhi_idle: got %h expected deadbeef", rd_data);
    end
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic test_noop;
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = 3'd0;
    rs_data  = 32'd9;
    rt_data  = 32'd9;
    @(negedge clk);
    for (int c = 6; c < 8; c++) begin
      op_code = 3'(c);
      #1;
      checks++;
      if ({stall, rd_data} !== 33'd0) begin
        errors++;
        $display("FAIL noop_%0d: got %b/%h expected 0/0",
                 c, stall, rd_data);
      end
      @(negedge clk);
    end
    op_valid = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (lo !== 32'd81) begin
      errors++;
      $display("FAIL noop_mul: got %h expected 51", lo);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int cyc;
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = 3'd0;
    rs_data  = 32'd3;
    rt_data  = 32'd5;
    @(negedge clk);
    rs_data = 32'd2;
    rt_data = 32'd2;
    n = 0;
    while (stall && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ({n, lo} !== {32'd34, 32'd15}) begin
      errors++;
      $display("FAIL b2b_first: got %0d/%h expected 34/f", n, lo);
    end
    @(negedge clk);
    op_valid = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    checks++;
    if (lo !== 32'd4) begin
      errors++;
      $display("FAIL b2b_second: got %h expected 4", lo);
    end
    checks++;
    if (done_cnt - d0 !== 2) begin
      errors++;
      $display("FAIL b2b_done_cnt: got %0d expected 2", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    int d0;
    write_hl(3'd2, 32'hAAAA_AAAA);
    write_hl(3'd3, 32'h5555_5555);
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = 3'd0;
    rs_data  = 32'h1234;
    rt_data  = 32'h5678;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    reset = 1'b1;
    op_valid = 1'b1;
    op_code  = 3'd4;
    #1;
    checks++;
    if ({hi, lo, stall, done} !== 66'd0) begin
      errors++;
      $display("FAIL reset_mid: got %h/%h/%b/%b expected 0/0/0/0",
               hi, lo, stall, done);
    end
    d0 = done_cnt;
    @(negedge clk);
    op_valid = 1'b0;
    reset = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (done_cnt !== d0) begin
      errors++;
      $display("FAIL reset_mid_done: got %0d expected %0d",
               done_cnt, d0);
    end
    run_mul(3'd0, 32'd6, 32'd7, cyc);
    checks++;
    if ({hi, lo} !== 64'd42) begin
      errors++;
      $display("FAIL after_reset_mul: got %h expected 2a", {hi, lo});
    end
  endtask

  task automatic test_random;
    int cyc;
    logic [2:0] code;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    for (int i = 0; i < 10; i++) begin
      code = 3'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if (i == 0) a = 32'h8000_0000;
      if (i == 1) b = 32'h8000_0000;
      exp = ref_prod(code[0], a, b);
      run_mul(code, a, b, cyc);
      checks++;
      if ({hi, lo} !== exp || cyc !== 34) begin
        errors++;
        $display("FAIL rand_%0d op%0d %h*%h: got %h/%0d expected %h/34",
                 i, code, a, b, {hi, lo}, cyc, exp);
      end
    end
  endtask

  initial begin
    test_reset;
    test_mult_basic;
    test_multu;
    test_mfhi_stall;
    test_mthi_mtlo;
    test_noop;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
